// File: rtl/graphics_pkg.sv
// Shared types and constants for the screen compositor.
// The floor colours are used only when FLOOR_LAYER_EN is defined.
package graphics_pkg;

    typedef logic [11:0] pixel_t;
    typedef logic [3:0]  tile_id_t;

    localparam pixel_t FLOOR_EVEN = 12'hCA8;
    localparam pixel_t FLOOR_ODD  = 12'hB97;

    // 16-entry tile palette. Entry 0 maps to the background colour; id 0
    // never reaches the palette because it renders as background or floor.
    function automatic pixel_t palette_color(input tile_id_t id);
        pixel_t c;
        case (id)
            4'd1:    c = 12'hF00;
            4'd2:    c = 12'h0F0;
            4'd3:    c = 12'h00F;
            4'd4:    c = 12'hFF0;
            4'd5:    c = 12'h0FF;
            4'd6:    c = 12'hF0F;
            4'd7:    c = 12'h888;
            4'd8:    c = 12'hF80;
            4'd9:    c = 12'h08F;
            4'd10:   c = 12'h8F0;
            4'd11:   c = 12'hF08;
            4'd12:   c = 12'h444;
            4'd13:   c = 12'hCCC;
            4'd14:   c = 12'h840;
            4'd15:   c = 12'h048;
            default: c = 12'hFFF;
        endcase
        return c;
    endfunction

    // Border shading halves the colour as one 12-bit word, so 12'hF00
    // shades to 12'h780.
    function automatic pixel_t shade(input pixel_t c);
        return c >> 1;
    endfunction

    // Index width that stays at least one bit for degenerate sizes.
    function automatic int clog2_min1(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tile_palette.sv
// Tile colour lookup with one registered cycle of latency.
// Configuration macro: FLOOR_LAYER_EN (id 0 inside the grid renders a
// checkerboard floor instead of the background colour).
module tile_palette
    import graphics_pkg::*;
#(
    parameter int     ROW_W    = 3,
    parameter int     COL_W    = 4,
    parameter int     SUB_W    = 5,
    parameter pixel_t BG_COLOR = 12'hFFF
) (
    input  logic             clock,
    input  logic             reset,
    input  tile_id_t         i_id,
    input  logic [SUB_W-1:0] i_sub_x,
    input  logic [SUB_W-1:0] i_sub_y,
    input  logic [ROW_W-1:0] i_row,
    input  logic [COL_W-1:0] i_col,
    input  logic             i_in_grid,
    output pixel_t           o_pixel
);

`ifdef FLOOR_LAYER_EN
    localparam bit FLOOR_EN = 1'b1;
`else
    localparam bit FLOOR_EN = 1'b0;
`endif

    logic   w_border;
    pixel_t w_base;
    pixel_t w_floor;

    assign w_border = (i_sub_x == '0) || (i_sub_y == '0);
    assign w_base   = palette_color(i_id);
    // Checkerboard parity of row+col equals (row ^ col) in the low bit.
    assign w_floor  = (((int'(i_row) + int'(i_col)) % 2) == 1) ? FLOOR_ODD : FLOOR_EVEN;

    // Register the tile colour: background, floor, shaded border or plain palette.
    always_ff @(posedge clock) begin
        if (reset) begin
            o_pixel <= '0;
        end else if (!i_in_grid) begin
            o_pixel <= BG_COLOR;
        end else if (i_id == '0) begin
            o_pixel <= FLOOR_EN ? w_floor : BG_COLOR;
        end else if (w_border) begin
            o_pixel <= shade(w_base);
        end else begin
            o_pixel <= w_base;
        end
    end

endmodule

// File: rtl/graphics_compositor.sv
// Three-stage screen compositor: tile addressing, tile palette lookup,
// player priority mux. Sync and blank are delayed to match the pixel.
// The tile grid is snapshotted on each vsync falling edge so a frame
// never mixes two grid states.
// Configuration macro: FLOOR_LAYER_EN (passed through to tile_palette).
module graphics_compositor
    import graphics_pkg::*;
#(
    parameter int     NUM_PLAYERS = 4,
    parameter int     GRID_ROWS   = 8,
    parameter int     GRID_COLS   = 13,
    parameter int     TILE_SIZE   = 32,
    parameter int     ORIGIN_X    = 112,
    parameter int     ORIGIN_Y    = 112,
    parameter pixel_t KEY_COLOR   = 12'hFFF,
    parameter pixel_t BG_COLOR    = 12'hFFF
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [$clog2(NUM_PLAYERS)-1:0]       num_players,
    input  logic [GRID_ROWS*GRID_COLS*4-1:0]     object_grid,
    input  logic [NUM_PLAYERS*12-1:0]            player_pixel,
    input  logic [10:0]                          hcount,
    input  logic [9:0]                           vcount,
    input  logic                                 hsync,
    input  logic                                 vsync,
    input  logic                                 blank,
    output logic                                 hsync_out,
    output logic                                 vsync_out,
    output logic                                 blank_out,
    output pixel_t                               pixel_out
);

    localparam int NP_W      = $clog2(NUM_PLAYERS);
    localparam int SUB_W     = $clog2(TILE_SIZE);
    localparam int ROW_W     = clog2_min1(GRID_ROWS);
    localparam int COL_W     = clog2_min1(GRID_COLS);
    localparam int NUM_TILES = GRID_ROWS * GRID_COLS;
    localparam int IDX_W     = clog2_min1(NUM_TILES);
    localparam int PL_W      = NUM_PLAYERS * 12;

    // Frame capture
    logic                   r_vsync_d;
    logic [NUM_TILES*4-1:0] r_shadow;

    // Stage 1
    logic [10:0]      w_off_x;
    logic [10:0]      w_off_y;
    logic             w_in_grid;
    logic             r_in_grid;
    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] r_col;
    logic [SUB_W-1:0] r_sub_x;
    logic [SUB_W-1:0] r_sub_y;
    logic [PL_W-1:0]  r_player1;
    logic [NP_W-1:0]  r_num1;
    logic             r_blank1, r_hs1, r_vs1, r_vld1;

    // Stage 2
    tile_id_t         w_tiles [NUM_TILES];
    logic [IDX_W-1:0] w_idx;
    tile_id_t         w_id;
    pixel_t           w_tile_pix;
    logic [PL_W-1:0]  r_player2;
    logic [NP_W-1:0]  r_num2;
    logic             r_blank2, r_hs2, r_vs2, r_vld2;

    // Stage 3
    pixel_t           w_mix;

    // Snapshot the grid on a registered vsync 1->0 detect; reset takes precedence.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_vsync_d <= 1'b1;
            r_shadow  <= '0;
        end else begin
            r_vsync_d <= vsync;
            if (r_vsync_d && !vsync) begin
                r_shadow <= object_grid;
            end
        end
    end

    // Offsets wrap as 11-bit unsigned, so pixels left of or above the grid fail the range test.
    assign w_off_x   = hcount - 11'(ORIGIN_X);
    assign w_off_y   = {1'b0, vcount} - 11'(ORIGIN_Y);
    assign w_in_grid = (w_off_x < 11'(GRID_COLS * TILE_SIZE)) &&
                       (w_off_y < 11'(GRID_ROWS * TILE_SIZE));

    // Stage 1: register tile coordinates and carry the side-band signals.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_in_grid <= 1'b0;
            r_row     <= '0;
            r_col     <= '0;
            r_sub_x   <= '0;
            r_sub_y   <= '0;
            r_player1 <= '0;
            r_num1    <= '0;
            r_blank1  <= 1'b1;
            r_hs1     <= 1'b1;
            r_vs1     <= 1'b1;
            r_vld1    <= 1'b0;
        end else begin
            r_in_grid <= w_in_grid;
            r_row     <= w_off_y[SUB_W +: ROW_W];
            r_col     <= w_off_x[SUB_W +: COL_W];
            r_sub_x   <= w_off_x[SUB_W-1:0];
            r_sub_y   <= w_off_y[SUB_W-1:0];
            r_player1 <= player_pixel;
            r_num1    <= num_players;
            r_blank1  <= blank;
            r_hs1     <= hsync;
            r_vs1     <= vsync;
            r_vld1    <= 1'b1;
        end
    end

    // Unpack the shadow grid into tile ids for row-major lookup.
    always_comb begin
        for (int i = 0; i < NUM_TILES; i++) begin
            w_tiles[i] = r_shadow[i*4 +: 4];
        end
    end

    // Off-grid coordinates are forced to tile 0 so the index never leaves the array.
    assign w_idx = r_in_grid ? (IDX_W'(r_row) * IDX_W'(GRID_COLS) + IDX_W'(r_col)) : '0;
    assign w_id  = w_tiles[w_idx];

    tile_palette #(
        .ROW_W    (ROW_W),
        .COL_W    (COL_W),
        .SUB_W    (SUB_W),
        .BG_COLOR (BG_COLOR)
    ) u_palette (
        .clock     (clock),
        .reset     (reset),
        .i_id      (w_id),
        .i_sub_x   (r_sub_x),
        .i_sub_y   (r_sub_y),
        .i_row     (r_row),
        .i_col     (r_col),
        .i_in_grid (r_in_grid),
        .o_pixel   (w_tile_pix)
    );

    // Stage 2: hold player data and side-band alongside the palette register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_player2 <= '0;
            r_num2    <= '0;
            r_blank2  <= 1'b1;
            r_hs2     <= 1'b1;
            r_vs2     <= 1'b1;
            r_vld2    <= 1'b0;
        end else begin
            r_player2 <= r_player1;
            r_num2    <= r_num1;
            r_blank2  <= r_blank1;
            r_hs2     <= r_hs1;
            r_vs2     <= r_vs1;
            r_vld2    <= r_vld1;
        end
    end

    // Priority mux: scan high to low so the lowest active non-key player wins.
    always_comb begin
        w_mix = w_tile_pix;
        for (int p = NUM_PLAYERS - 1; p >= 0; p--) begin
            if ((p <= int'(r_num2)) && (r_player2[p*12 +: 12] != KEY_COLOR)) begin
                w_mix = r_player2[p*12 +: 12];
            end
        end
    end

    // Stage 3: registered outputs; blanked or not-yet-valid pixels are black.
    always_ff @(posedge clock) begin
        if (reset) begin
            pixel_out <= '0;
            blank_out <= 1'b1;
            hsync_out <= 1'b1;
            vsync_out <= 1'b1;
        end else begin
            pixel_out <= (r_vld2 && !r_blank2) ? w_mix : '0;
            blank_out <= r_blank2;
            hsync_out <= r_hs2;
            vsync_out <= r_vs2;
        end
    end

endmodule

// File: tb/tb_graphics_compositor.sv
// Self-checking bench for graphics_compositor: directed cases followed by
// randomized pixels, all scored against a behavioural model with a
// three-cycle expectation queue.
module tb_graphics_compositor;

    localparam int NP   = 4;
    localparam int ROWS = 8;
    localparam int COLS = 13;
    localparam int GB   = ROWS * COLS * 4;
    localparam int TS   = 32;
    localparam int OX   = 112;
    localparam int OY   = 112;

    logic            clock = 1'b0;
    logic            reset;
    logic [1:0]      num_players;
    logic [GB-1:0]   object_grid;
    logic [NP*12-1:0] player_pixel;
    logic [10:0]     hcount;
    logic [9:0]      vcount;
    logic            hsync, vsync, blank;
    logic            hsync_out, vsync_out, blank_out;
    logic [11:0]     pixel_out;

    graphics_compositor dut (
        .clock        (clock),
        .reset        (reset),
        .num_players  (num_players),
        .object_grid  (object_grid),
        .player_pixel (player_pixel),
        .hcount       (hcount),
        .vcount       (vcount),
        .hsync        (hsync),
        .vsync        (vsync),
        .blank        (blank),
        .hsync_out    (hsync_out),
        .vsync_out    (vsync_out),
        .blank_out    (blank_out),
        .pixel_out    (pixel_out)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Stimulus for the next cycle
    logic [10:0]      s_h;
    logic [9:0]       s_v;
    logic             s_hs, s_vs, s_bl;
    logic [1:0]       s_num;
    logic [NP*12-1:0] s_pl;
    logic [GB-1:0]    s_grid;
    string            s_tag;
    int               s_ovr;

    // Model state and expectation queues
    logic [GB-1:0]    m_grid;
    logic             m_vs_prev;
    logic [11:0]      q_pix [$];
    logic [2:0]       q_sync [$];
    string            q_tag [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] pal(input int id);
        case (id)
            1:  return 12'hF00;
            2:  return 12'h0F0;
            3:  return 12'h00F;
            4:  return 12'hFF0;
            5:  return 12'h0FF;
            6:  return 12'hF0F;
            7:  return 12'h888;
            8:  return 12'hF80;
            9:  return 12'h08F;
            10: return 12'h8F0;
            11: return 12'hF08;
            12: return 12'h444;
            13: return 12'hCCC;
            14: return 12'h840;
            15: return 12'h048;
            default: return 12'hFFF;
        endcase
    endfunction

    function automatic logic [11:0] ref_pix(input logic [10:0] h, input logic [9:0] v,
                                            input logic bl, input logic [1:0] num,
                                            input logic [NP*12-1:0] pl, input logic [GB-1:0] g);
        int x, y, r, c, id;
        logic [11:0] res;
        logic found;
        found = 1'b0;
        res = 12'hFFF;
        if (bl) return 12'h000;
        for (int p = 0; p < NP; p++) begin
            if (!found && p <= int'(num) && pl[p*12 +: 12] != 12'hFFF) begin
                res = pl[p*12 +: 12];
                found = 1'b1;
            end
        end
        if (found) return res;
        x = int'(h) - OX;
        y = int'(v) - OY;
        if (x < 0 || x >= COLS * TS || y < 0 || y >= ROWS * TS) return 12'hFFF;
        r  = y / TS;
        c  = x / TS;
        id = int'(g[(r*COLS + c)*4 +: 4]);
        if (id == 0) begin
`ifdef FLOOR_LAYER_EN
            return (((r + c) % 2) == 1) ? 12'hB97 : 12'hCA8;
`else
            return 12'hFFF;
`endif
        end
        res = pal(id);
        if ((x % TS) == 0 || (y % TS) == 0) return res >> 1;
        return res;
    endfunction

    // One pixel clock: score the item now leaving the pipe, then apply the next one.
    task automatic step();
        string       t;
        logic [11:0] ep;
        logic [2:0]  es;
        @(negedge clock);
        if (q_pix.size() == 3) begin
            t  = q_tag.pop_front();
            ep = q_pix.pop_front();
            es = q_sync.pop_front();
            chk({t, "/pix"}, 32'(pixel_out), 32'(ep));
            chk({t, "/sync"}, 32'({hsync_out, vsync_out, blank_out}), 32'(es));
        end
        hcount       = s_h;
        vcount       = s_v;
        hsync        = s_hs;
        vsync        = s_vs;
        blank        = s_bl;
        num_players  = s_num;
        player_pixel = s_pl;
        object_grid  = s_grid;
        if (m_vs_prev && !s_vs) m_grid = s_grid;
        m_vs_prev = s_vs;
        if (s_ovr >= 0) ep = s_ovr[11:0];
        else            ep = ref_pix(s_h, s_v, s_bl, s_num, s_pl, m_grid);
        q_pix.push_back(ep);
        q_sync.push_back({s_hs, s_vs, s_bl});
        q_tag.push_back(s_tag);
        s_ovr = -1;
    endtask

    task automatic px(input int h, input int v, input int ovr, input string tag);
        s_h   = 11'(h);
        s_v   = 10'(v);
        s_bl  = 1'b0;
        s_ovr = ovr;
        s_tag = tag;
        step();
    endtask

    task automatic vs_pulse();
        s_bl  = 1'b1;
        s_vs  = 1'b0;
        s_tag = "vs_lo";
        step();
        s_vs  = 1'b1;
        s_tag = "vs_hi";
        step();
    endtask

    task automatic do_reset(input int n, input string tag);
        @(negedge clock);
        reset = 1'b1;
        vsync = 1'b1;
        s_vs  = 1'b1;
        q_pix.delete();
        q_sync.delete();
        q_tag.delete();
        m_grid    = '0;
        m_vs_prev = 1'b1;
        repeat (n) @(negedge clock);
        chk({tag, "/pix"}, 32'(pixel_out), 32'h0);
        chk({tag, "/blank"}, 32'(blank_out), 32'h1);
        chk({tag, "/hsync"}, 32'(hsync_out), 32'h1);
        chk({tag, "/vsync"}, 32'(vsync_out), 32'h1);
        reset = 1'b0;
    endtask

    task automatic set_tile(input int r, input int c, input int id);
        s_grid[(r*COLS + c)*4 +: 4] = 4'(id);
    endtask

    task automatic set_player(input int p, input logic [11:0] col);
        s_pl[p*12 +: 12] = col;
    endtask

    initial begin
        reset        = 1'b1;
        hcount       = '0;
        vcount       = '0;
        hsync        = 1'b1;
        vsync        = 1'b1;
        blank        = 1'b1;
        num_players  = 2'd3;
        player_pixel = {NP{12'hFFF}};
        object_grid  = '0;
        s_h = '0; s_v = '0; s_hs = 1'b1; s_vs = 1'b1; s_bl = 1'b1;
        s_num = 2'd3; s_pl = {NP{12'hFFF}}; s_grid = '0; s_tag = "idle"; s_ovr = -1;
        m_grid = '0; m_vs_prev = 1'b1;

        // Reset values, then hsync delay alignment
        do_reset(4, "reset");
        for (int i = 0; i < 8; i++) begin
            s_hs = (i % 3 == 1) ? 1'b0 : 1'b1;
            px(20 + i, 40, -1, "hsync_dly");
        end
        s_hs = 1'b1;

        // Tile capture, border shading and plain tile
        set_tile(0, 0, 1);
        vs_pulse();
        px(112, 113, 12'h780, "border");
        px(120, 120, 12'hF00, "tile1");

        // Grid change without vsync edge is invisible until the next edge
        set_tile(0, 0, 2);
        px(120, 120, 12'hF00, "no_capture");
        vs_pulse();
        px(120, 120, 12'h0F0, "capture");

        // Player priority and active-player limit
        s_num = 2'd1;
        set_player(0, 12'hFFF);
        set_player(1, 12'h0F0);
        set_player(2, 12'h00F);
        set_player(3, 12'hFFF);
        px(300, 300, 12'h0F0, "prio_p1");
        set_player(0, 12'h123);
        px(300, 300, 12'h123, "prio_p0");
        s_num = 2'd0;
        set_player(0, 12'hFFF);
        px(50, 50, 12'hFFF, "ignored_p1");
        s_num = 2'd3;
        set_player(1, 12'hFFF);
        set_player(2, 12'hFFF);
        set_player(3, 12'h0FF);
        px(50, 50, 12'h0FF, "p3_active");
        set_player(3, 12'hFFF);

        // Grid boundaries, including the unsigned wrap at hcount 0
        px(111, 120, 12'hFFF, "left_edge");
        px(112 + 13 * 32, 120, 12'hFFF, "right_edge");
        px(0, 120, 12'hFFF, "wrap_h0");
        px(120, 111, 12'hFFF, "top_edge");
        px(120, 112 + 8 * 32, 12'hFFF, "bottom_edge");
        px(112 + 13 * 32 - 1, 120, -1, "last_col");

        // Tile id 0 inside the grid: floor checkerboard or background
`ifdef FLOOR_LAYER_EN
        px(120, 150, 12'hB97, "floor_r1c0");
        px(150, 150, 12'hCA8, "floor_r1c1");
`else
        px(120, 150, 12'hFFF, "floor_r1c0");
        px(150, 150, 12'hFFF, "floor_r1c1");
`endif

        // Blank forces black even over a player
        set_player(2, 12'h00F);
        s_h = 11'd120; s_v = 10'd120; s_bl = 1'b1; s_tag = "blank_black"; s_ovr = 0;
        step();
        set_player(2, 12'hFFF);

        // Mid-frame reset clears the outputs and the shadow grid
        set_tile(0, 0, 1);
        vs_pulse();
        px(120, 120, 12'hF00, "pre_rst");
        do_reset(1, "mid_reset");
        px(120, 120, 12'hFFF, "post_rst_shadow");
        px(125, 125, 12'hFFF, "post_rst_shadow2");
        vs_pulse();
        px(120, 120, 12'hF00, "post_rst_capture");

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 19) == 0) begin
                for (int i = 0; i < ROWS * COLS; i++) s_grid[i*4 +: 4] = 4'($urandom_range(0, 15));
            end
            for (int p = 0; p < NP; p++) begin
                s_pl[p*12 +: 12] = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'hFFF;
            end
            s_h   = 11'($urandom_range(0, 700));
            s_v   = 10'($urandom_range(0, 500));
            s_bl  = ($urandom_range(0, 9) == 0);
            s_hs  = 1'($urandom);
            s_vs  = ($urandom_range(0, 19) == 0) ? 1'b0 : 1'b1;
            s_num = 2'($urandom);
            s_tag = "random";
            s_ovr = -1;
            step();
        end

        // Drain the pipe
        s_bl  = 1'b1;
        s_vs  = 1'b1;
        s_tag = "drain";
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
